bw_seq_mult: RTL and testbench
==============================

// Module: bw_seq_mult
// PURPOSE
//  Iterative signed (two's complement) WA x WB Baugh-Wooley multiplier.
//  Sits as the sequential, area-reduced alternative to the combinational
//  7x5 HA/FA array, and is used where the same product is tolerable over
//  WB+1 cycles. Adds one Baugh-Wooley partial-product row per clock into
//  an accumulator. Uses a start/busy/done handshake.
// PARAMETERS
//  WA  7  multiplicand width, signed, >=2
//  WB  5  multiplier width, signed, >=2
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst_n  in   1      asynchronous reset, active-low
//  start  in   1      request; sampled only in IDLE
//  a      in   WA     signed multiplicand, sampled with start
//  b      in   WB     signed multiplier, sampled with start
//  busy   out  1      high while an operation is in progress (RUN)
//  done   out  1      one-cycle pulse: p has just been updated
//  p      out  WA+WB  signed product; held until the next completion
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, p=0, acc=0, cnt=0.
//   Reset asserted mid-RUN aborts the operation; no done, p=0.
//  State IDLE (busy=0):
//   - start=1 at edge k: latch a->ra, b->rb; acc <= CONST; cnt <= 0; go RUN.
//   - start=0: stay in IDLE.
//   - done deasserts on the first edge after its pulse.
//  CONST = 2^(WA+WB-1) + 2^(WA-1) + 2^(WB-1), computed mod 2^(WA+WB).
//   Default: 0x800 + 0x040 + 0x010 = 0x850.
//  State RUN (busy=1), one row per edge, j=cnt:
//   - j<WB-1: row bits i<WA-1 = ra[i]&rb[j]; bit WA-1 = ~(ra[WA-1]&rb[j]).
//   - j=WB-1: row bits i<WA-1 = ~(ra[i]&rb[j]); bit WA-1 = ra[WA-1]&rb[j].
//   - acc <= acc + (row << j), mod 2^(WA+WB). Carries out of the MSB are
//     discarded.
//   - On the edge that adds row WB-1: p <= final sum; done <= 1; busy <= 0;
//     go IDLE.
//   - Otherwise: cnt <= cnt+1.
//  Latency: start sampled at edge k -> done=1 and p valid after edge k+WB.
//   Default: 5 edges after start, 6 cycles start-to-start.
//  start while busy=1 is ignored: no queueing and no operand change.
//   Changes on a/b during RUN have no effect.
//  start=1 in the done cycle (state is IDLE) is accepted. p keeps the old
//   result until the new completion. Back-to-back throughput is therefore
//   one result per WB+1 cycles.
//  p equals the exact signed product for all inputs; no overflow is
//   possible in WA+WB bits. Extremes: (-2^(WA-1))*(-2^(WB-1)) = +2^(WA+WB-2).
//  cnt width = clog2(WB). No combinational path from inputs to outputs;
//   all outputs are registered.
// TESTING
//  1 a=3,   b=5   start 1 cycle -> busy 5 cycles; done pulse; p=15 (0x00F)
//  2 a=-64, b=-16 -> p=1024 (0x400); a=63, b=15 -> p=945 (0x3B1)
//  3 a=-64, b=15  -> p=-960 (0xC40); a=-1, b=1 -> p=-1 (0xFFF);
//    a=0, b=-16   -> p=0
//  4 start held high continuously with a=2, b=3 then a=-2, b=3 ->
//    done every 6 cycles; p=6, then p=-6 (0xFFA)
//  5 start pulsed again mid-RUN with new operands -> ignored;
//    original product reported
//  6 rst_n low for 1 cycle at cycle 3 of RUN -> busy=0, done=0, p=0
//    immediately; the next op (a=7, b=-3) gives p=-21 (0xFEB)
//  Exhaustive: all 2^12 (a,b) pairs vs the $signed reference product
//   (mandatory final regression).

Source files
------------

// File: rtl/bw_seq_mult.sv
// Iterative signed Baugh-Wooley multiplier: one partial-product row per clock
// into an accumulator, with a start/busy/done handshake.
module bw_seq_mult #(
  parameter int WA = 7,
  parameter int WB = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic             busy,
  output logic             done,
  output logic [WA+WB-1:0] p
);

  // state | meaning
  // IDLE  | waiting for start; p holds the last result
  // RUN   | adding row cnt of the partial-product array into acc

  localparam int W  = WA + WB;
  localparam int CW = $clog2(WB);
  // Sign-correction constant that turns the inverted rows into a signed sum.
  localparam logic [W-1:0] CONST =
    W'((64'd1 << (W - 1)) + (64'd1 << (WA - 1)) + (64'd1 << (WB - 1)));

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [WA-1:0]   ra;
  logic [WB-1:0]   rb;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic            bj;
  logic            last;
  logic [WA-1:0]   row;
  logic [W-1:0]    sum;

  // The last row (multiplier sign bit) inverts the low bits instead of the MSB.
  always_comb begin
    bj   = rb[cnt];
    last = (cnt == CW'(WB - 1));
    row  = {(ra[WA-1] & bj) ^ ~last,
            (ra[WA-2:0] & {(WA-1){bj}}) ^ {(WA-1){last}}};
    sum  = acc + ({{WB{1'b0}}, row} << cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      acc   <= '0;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            acc   <= CONST;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          if (last) begin
            p     <= sum;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bw_seq_mult.sv
// Scoreboard bench for bw_seq_mult: a cycle-level protocol model pushes
// expected products on accepted starts; the monitor pops them on done.
module tb_bw_seq_mult;

  localparam int WA = 7;
  localparam int WB = 5;
  localparam int W  = WA + WB;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic          busy;
  logic          done;
  logic [W-1:0]  p;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] held_p;
  int           mcnt;
  logic         exp_done;

  bw_seq_mult #(.WA(WA), .WB(WB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_prod(input logic [WA-1:0] aa, input logic [WB-1:0] bb);
    int sa;
    int sb;
    int x;
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    x  = sa * sb;
    return W'(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: idle accepts start, then the result is due WB edges later.
  initial begin
    mcnt = 0; exp_done = 1'b0; held_p = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mcnt = 0; exp_done = 1'b0; held_p = '0;
        q.delete();
      end else begin
        exp_done = 1'b0;
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) exp_done = 1'b1;
        end else if (start) begin
          q.push_back(ref_prod(a, b));
          mcnt = WB;
        end
      end
    end
  end

  // Monitor: compares handshake every cycle and pops a result on each done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy", 32'(busy), 32'(mcnt != 0));
      chk("done", 32'(done), 32'(exp_done));
      if (done) begin
        chk("sb_has_entry", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          held_p = q.pop_front();
          chk("product", 32'(p), 32'(held_p));
        end
      end else begin
        chk("p_hold", 32'(p), 32'(held_p));
      end
    end
  end

  task automatic run_op(input logic [WA-1:0] ia, input logic [WB-1:0] ib);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
    repeat (WB - 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_p", 32'(p), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // directed patterns
    run_op(7'd3, 5'd5);
    run_op(7'(-64), 5'(-16));
    run_op(7'd63, 5'd15);
    run_op(7'(-64), 5'd15);
    run_op(7'(-1), 5'd1);
    run_op(7'd0, 5'(-16));
    repeat (3) @(negedge clk);

    // start held high: back-to-back every WB+1 cycles
    start = 1'b1; a = 7'd2; b = 5'd3;
    repeat (WB + 1) @(negedge clk);
    a = 7'(-2);
    repeat (WB + 1) @(negedge clk);
    start = 1'b0;
    repeat (WB + 2) @(negedge clk);

    // start mid-RUN with new operands is ignored
    start = 1'b1; a = 7'd5; b = 5'(-7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 7'd9; b = 5'd9;
    @(negedge clk);
    start = 1'b0; a = 7'd33; b = 5'd2;
    repeat (WB + 2) @(negedge clk);

    // reset in the middle of RUN aborts
    start = 1'b1; a = 7'd17; b = 5'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_p", 32'(p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(7'd7, 5'(-3));
    repeat (2) @(negedge clk);

    // random traffic, including starts while busy
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = WA'($urandom);
      b = WB'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (WB + 2) @(negedge clk);

    // exhaustive regression
    for (int ia = 0; ia < (1 << WA); ia++) begin
      for (int ib = 0; ib < (1 << WB); ib++) begin
        run_op(WA'(ia), WB'(ib));
      end
    end
    repeat (WB + 3) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
